// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, omod encoding and classification helpers for
// the FP32 adder result stage.
package fp32_pkg;

   localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;
   localparam logic [31:0] FP32_PZERO   = 32'h0000_0000;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      OMOD_NONE = 2'd0,
      OMOD_X2   = 2'd1,
      OMOD_X4   = 2'd2,
      OMOD_DIV2 = 2'd3
   } omod_e;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == FP32_EXP_MAX) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic is_inf(input logic [31:0] v);
      return (v[30:23] == FP32_EXP_MAX) && (v[22:0] == 23'd0);
   endfunction

endpackage

// File: rtl/fp32_add_result_stage_fifo.sv
// result_fifo: generic synchronous FIFO with registered storage.
//   Parameters : DEPTH (power of two, >= 2), WIDTH
//   Ports      : clk, rst_n (async active-low)
//                i_push/i_wdata  write side (ignored when full)
//                i_pop/o_rdata   read side, o_rdata is the head entry
//                                (ignored when empty)
//                o_count, o_full, o_empty  occupancy status
module result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 40
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_wdata,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage is reset so the head reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fp32_add_result_stage.sv
// fp32_add_result_stage: post-adder stage applying omod (optional) and clamp,
// buffering results toward VGPR writeback, with sticky NaN/overflow flags and
// a retired-result counter.
//   Optional feature macro: FP32_RESULT_OMOD_EN (omod modifier logic).
//   Ports: in_*   adder result handshake + flags, dst index, modifiers
//          out_*  writeback handshake, data, dst index
//          sticky_clr/sticky_nan/sticky_ovf  exception flags
//          result_count                      out handshakes, wrapping
module fp32_add_result_stage
   import fp32_pkg::*;
#(
   parameter int unsigned DST_W = 8,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_result,
   input  logic              in_nan,
   input  logic              in_ovf,
   input  logic [DST_W-1:0]  in_dst,
   input  logic              in_clamp,
   input  logic [1:0]        in_omod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [DST_W-1:0]  out_dst,
   input  logic              sticky_clr,
   output logic              sticky_nan,
   output logic              sticky_ovf,
   output logic [CNT_W-1:0]  result_count
);

   logic [31:0]           w_omod_val;
   logic                  w_omod_ovf;
   logic [31:0]           w_final;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [31+DST_W:0]     w_rdata;
   logic [$clog2(DEPTH):0] w_fifo_count_unused;
   logic                  r_sticky_nan;
   logic                  r_sticky_ovf;
   logic [CNT_W-1:0]      r_result_count;

`ifdef FP32_RESULT_OMOD_EN
   logic [9:0] w_exp_adj;
   logic       w_omod_apply;

   // Only finite, nonzero normals are scaled; exponent adjust is done in a
   // widened field so overflow/underflow are detectable.
   always_comb begin
      w_omod_val   = in_result;
      w_omod_ovf   = 1'b0;
      w_exp_adj    = {2'b00, in_result[30:23]};
      w_omod_apply = (in_result[30:23] != 8'h00) && (in_result[30:23] != FP32_EXP_MAX);
      case (omod_e'(in_omod))
         OMOD_X2:   w_exp_adj = w_exp_adj + 10'd1;
         OMOD_X4:   w_exp_adj = w_exp_adj + 10'd2;
         OMOD_DIV2: w_exp_adj = w_exp_adj - 10'd1;
         default:   w_omod_apply = 1'b0;
      endcase
      if (w_omod_apply) begin
         if (w_exp_adj >= {2'b00, FP32_EXP_MAX}) begin
            w_omod_val = {in_result[31], FP32_EXP_MAX, 23'd0};
            w_omod_ovf = 1'b1;
         end else if (w_exp_adj == 10'd0) begin
            w_omod_val = {in_result[31], 31'd0};
         end else begin
            w_omod_val = {in_result[31], w_exp_adj[7:0], in_result[22:0]};
         end
      end
   end
`else
   logic w_omod_unused;
   assign w_omod_unused = ^in_omod;
   assign w_omod_val    = in_result;
   assign w_omod_ovf    = 1'b0;
`endif

   // Clamp to [0,1]: NaN and any negative (incl. -0, -inf) go to +0.
   always_comb begin
      w_final = w_omod_val;
      if (in_clamp) begin
         if (is_nan(w_omod_val) || w_omod_val[31]) begin
            w_final = FP32_PZERO;
         end else if (is_inf(w_omod_val) || (w_omod_val >= FP32_ONE)) begin
            w_final = FP32_ONE;
         end
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign out_data  = w_rdata[DST_W +: 32];
   assign out_dst   = w_rdata[DST_W-1:0];

   result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32 + DST_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({w_final, in_dst}),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_count (w_fifo_count_unused),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_nan <= 1'b0;
         r_sticky_ovf <= 1'b0;
      end else begin
         if (w_push && (in_nan || is_nan(w_omod_val))) r_sticky_nan <= 1'b1;
         else if (sticky_clr)                          r_sticky_nan <= 1'b0;
         if (w_push && (in_ovf || w_omod_ovf))         r_sticky_ovf <= 1'b1;
         else if (sticky_clr)                          r_sticky_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_result_count <= '0;
      else if (w_pop) r_result_count <= r_result_count + 1'b1;
   end

   assign sticky_nan   = r_sticky_nan;
   assign sticky_ovf   = r_sticky_ovf;
   assign result_count = r_result_count;

endmodule

// File: tb/tb_fp32_add_result_stage.sv
module tb_fp32_add_result_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic        in_nan = 1'b0;
   logic        in_ovf = 1'b0;
   logic [7:0]  in_dst = '0;
   logic        in_clamp = 1'b0;
   logic [1:0]  in_omod = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [7:0]  out_dst;
   logic        sticky_clr = 1'b0;
   logic        sticky_nan;
   logic        sticky_ovf;
   logic [15:0] result_count;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_cnt = '0;

   always #5 clk = ~clk;

   fp32_add_result_stage #(.DST_W(8), .DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_nan(in_nan), .in_ovf(in_ovf), .in_dst(in_dst),
      .in_clamp(in_clamp), .in_omod(in_omod),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dst(out_dst),
      .sticky_clr(sticky_clr), .sticky_nan(sticky_nan), .sticky_ovf(sticky_ovf),
      .result_count(result_count)
   );

   // Drives one beat for a single clock edge; called at #1 after an edge.
   task automatic send(input logic [31:0] d, input logic nan, input logic ovf,
                       input logic [7:0] dst, input logic clamp,
                       input logic [1:0] omod, input logic clr);
      in_result = d; in_nan = nan; in_ovf = ovf; in_dst = dst;
      in_clamp = clamp; in_omod = omod; sticky_clr = clr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; sticky_clr = 1'b0; in_nan = 1'b0; in_ovf = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
      total++; if (out_dst !== 8'h0) begin bad++; $display("FAIL reset_out_dst got=%h want=00", out_dst); end
      total++; if ({sticky_nan, sticky_ovf} !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%b want=00", {sticky_nan, sticky_ovf}); end
      total++; if (result_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", result_count); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(32'h4040_0000, 1'b0, 1'b0, 8'd5, 1'b0, 2'd0, 1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
      total++; if (out_data !== 32'h4040_0000) begin bad++; $display("FAIL basic_data got=%h want=40400000", out_data); end
      total++; if (out_dst !== 8'd5) begin bad++; $display("FAIL basic_dst got=%0d want=5", out_dst); end
      tick(); exp_cnt++;
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL basic_count got=%0d want=%0d", result_count, exp_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_clamp();
      logic [31:0] vin  [7] = '{32'h4040_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h3F7F_FFFF,
                                32'h7F80_0000, 32'hFF80_0000, 32'hBF80_0000};
      logic        vnan [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        vclp [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] vexp [7] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F7F_FFFF,
                                32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(vin[i], vnan[i], 1'b0, 8'(i + 16), vclp[i], 2'd0, 1'b0);
         total++; if (out_data !== vexp[i]) begin bad++; $display("FAIL clamp_%0d got=%h want=%h", i, out_data, vexp[i]); end
         total++; if (out_dst !== 8'(i + 16)) begin bad++; $display("FAIL clamp_dst_%0d got=%0d want=%0d", i, out_dst, i + 16); end
         if (i == 2) begin
            total++; if (sticky_nan !== 1'b1) begin bad++; $display("FAIL clamp_sticky_nan got=%b want=1", sticky_nan); end
         end
         tick(); exp_cnt++;
      end
      // Clear, then set via a NaN pattern alone (in_nan low), unclamped.
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      total++; if (sticky_nan !== 1'b0) begin bad++; $display("FAIL clamp_nan_clr got=%b want=0", sticky_nan); end
      send(32'h7FC0_0001, 1'b0, 1'b0, 8'd3, 1'b0, 2'd0, 1'b0);
      total++; if (out_data !== 32'h7FC0_0001) begin bad++; $display("FAIL noclamp_nan got=%h want=7fc00001", out_data); end
      total++; if (sticky_nan !== 1'b1) begin bad++; $display("FAIL prenan_sticky got=%b want=1", sticky_nan); end
      tick(); exp_cnt++;
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL clamp_count got=%0d want=%0d", result_count, exp_cnt); end
   endtask

   task automatic test_sticky();
      out_ready = 1'b1;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL sticky_ovf_init got=%b want=0", sticky_ovf); end
      send(32'h7F80_0000, 1'b0, 1'b1, 8'd1, 1'b0, 2'd0, 1'b0);
      total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL sticky_ovf_set got=%b want=1", sticky_ovf); end
      tick(); exp_cnt++;
      send(32'h7F80_0000, 1'b0, 1'b1, 8'd2, 1'b0, 2'd0, 1'b1);
      total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b want=1", sticky_ovf); end
      tick(); exp_cnt++;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      total++; if ({sticky_nan, sticky_ovf} !== 2'b00) begin bad++; $display("FAIL sticky_clr got=%b want=00", {sticky_nan, sticky_ovf}); end
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL sticky_count got=%0d want=%0d", result_count, exp_cnt); end
   endtask

   task automatic test_omod();
`ifdef FP32_RESULT_OMOD_EN
      logic [31:0] vin  [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h7FC0_0000, 32'h7F00_0000};
      logic [1:0]  vmod [5] = '{2'd1, 2'd3, 2'd3, 2'd1, 2'd2};
      logic [31:0] vexp [5] = '{32'h4000_0000, 32'h3F00_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000};
      logic        vovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
      logic [31:0] vin  [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h4040_0000, 32'h7F00_0000};
      logic [1:0]  vmod [5] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
      logic [31:0] vexp [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h4040_0000, 32'h7F00_0000};
      logic        vovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(vin[i], 1'b0, 1'b0, 8'd9, 1'b0, vmod[i], 1'b0);
         total++; if (out_data !== vexp[i]) begin bad++; $display("FAIL omod_%0d got=%h want=%h", i, out_data, vexp[i]); end
         total++; if (sticky_ovf !== vovf[i]) begin bad++; $display("FAIL omod_ovf_%0d got=%b want=%b", i, sticky_ovf, vovf[i]); end
         tick(); exp_cnt++;
      end
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      in_omod = 2'd0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      out_ready = 1'b1; in_clamp = 1'b0; in_omod = 2'd0;
      for (int i = 0; i < 4; i++) begin
         in_result = d[i]; in_dst = 8'(i); in_valid = 1'b1;
         tick();
         total++; if (out_data !== d[i] || out_dst !== 8'(i)) begin bad++; $display("FAIL b2b_%0d got=%h/%0d want=%h/%0d", i, out_data, out_dst, d[i], i); end
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b want=1", i, in_ready); end
      end
      in_valid = 1'b0;
      tick(); exp_cnt = exp_cnt + 16'd4;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", out_valid); end
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", result_count, exp_cnt); end
   endtask

   task automatic test_backpressure();
      logic [31:0] d [3] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
      int acc = 0;
      out_ready = 1'b0; in_clamp = 1'b0; in_omod = 2'd0;
      for (int i = 0; i < 3; i++) begin
         in_result = d[acc]; in_dst = 8'(acc + 40); in_valid = 1'b1;
         if (in_ready) acc++;
         tick();
      end
      total++; if (acc !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
      total++; if (out_data !== d[0] || out_dst !== 8'd40) begin bad++; $display("FAIL bp_head_hold got=%h/%0d want=%h/40", out_data, out_dst, d[0]); end
      // Full with out_ready high: pop only; C stays offered.
      out_ready = 1'b1;
      tick(); exp_cnt++;
      total++; if (out_data !== d[1]) begin bad++; $display("FAIL bp_pop1 got=%h want=%h", out_data, d[1]); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
      tick(); exp_cnt++;
      in_valid = 1'b0;
      total++; if (out_data !== d[2] || out_dst !== 8'd42) begin bad++; $display("FAIL bp_pop2 got=%h/%0d want=%h/42", out_data, out_dst, d[2]); end
      tick(); exp_cnt++;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL bp_count got=%0d want=%0d", result_count, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(32'h5555_5555, 1'b1, 1'b0, 8'd7, 1'b0, 2'd0, 1'b0);
      send(32'h6666_6666, 1'b0, 1'b1, 8'd8, 1'b0, 2'd0, 1'b0);
      total++; if ({out_valid, in_ready, sticky_nan, sticky_ovf} !== 4'b1011) begin bad++; $display("FAIL mid_pre got=%b want=1011", {out_valid, in_ready, sticky_nan, sticky_ovf}); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
      total++; if (result_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", result_count); end
      total++; if ({sticky_nan, sticky_ovf} !== 2'b00) begin bad++; $display("FAIL mid_sticky got=%b want=00", {sticky_nan, sticky_ovf}); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h want=00000000", out_data); end
      #1 rst_n = 1'b1;
      exp_cnt = '0;
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_after got=%b%b want=01", out_valid, in_ready); end
      out_ready = 1'b1;
      send(32'h7777_7777, 1'b0, 1'b0, 8'd9, 1'b0, 2'd0, 1'b0);
      total++; if (out_data !== 32'h7777_7777) begin bad++; $display("FAIL mid_fresh got=%h want=77777777", out_data); end
      tick(); exp_cnt++;
      total++; if (result_count !== exp_cnt) begin bad++; $display("FAIL mid_fresh_count got=%0d want=%0d", result_count, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_sticky();
      test_omod();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
